// File: rtl/idli_issue_m.sv
// Purpose : fetch/issue sequencer; owns the slice counter and fetch pc, buffers fetched words, streams head encoding.
// Latency : a word delivered in slot N is first streamed in slot N+1 (no same-slot bypass).
// Backpress: fetch request drops while the queue is full; i_is_stall holds the head for another slot.
//
// Ports:
//   i_is_gck / i_is_rst_n           clock, async active-low reset
//   o_is_ctr                        free-running slice counter, slot = ctr 0..3
//   o_is_mem_req / o_is_mem_pc      word fetch request and its address (stable across a slot)
//   i_is_mem_data / i_is_mem_vld    serial word slices (LSB first), vld sampled at ctr==3
//   o_is_enc / o_is_enc_vld         head encoding slice for the current ctr, head valid
//   i_is_stall                      sampled at ctr==3: keep the head, re-stream next slot
//   i_is_redirect / i_is_redirect_pc sampled at ctr==3: flush queue and refetch from new pc
module idli_issue_m #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_is_gck,
    input  logic        i_is_rst_n,
    output logic [1:0]  o_is_ctr,
    output logic        o_is_mem_req,
    output logic [15:0] o_is_mem_pc,
    input  logic [3:0]  i_is_mem_data,
    input  logic        i_is_mem_vld,
    output logic [3:0]  o_is_enc,
    output logic        o_is_enc_vld,
    input  logic        i_is_stall,
    input  logic        i_is_redirect,
    input  logic [15:0] i_is_redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    ctr;
    logic [11:0]   asm_q;          // nibbles 0..2 of the word in flight; nibble 3 is taken live
    logic [15:0]   q_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   pc;

    logic          boundary;
    logic [15:0]   word;
    logic [15:0]   head;
    logic          push;
    logic          pop;

    assign boundary = (ctr == 2'd3);
    assign word     = {i_is_mem_data, asm_q};
    assign head     = q_mem[rd_ptr];

    assign o_is_ctr     = ctr;
    assign o_is_mem_pc  = pc;
    assign o_is_mem_req = (count < CW'(DEPTH));
    assign o_is_enc     = head[{ctr, 2'b00} +: 4];
    // Redirect kills the head in the boundary cycle itself, not just from the next slot.
    assign o_is_enc_vld = (count != '0) && !(boundary && i_is_redirect);

    // Push requires our own request: a vld with the queue full is ignored.
    assign push = boundary && o_is_mem_req && i_is_mem_vld && !i_is_redirect;
    assign pop  = boundary && (count != '0) && !i_is_stall && !i_is_redirect;

    always_ff @(posedge i_is_gck or negedge i_is_rst_n) begin
        if (!i_is_rst_n) begin
            ctr <= 2'd0;
        end else begin
            ctr <= ctr + 2'd1;
        end
    end

    always_ff @(posedge i_is_gck or negedge i_is_rst_n) begin
        if (!i_is_rst_n) begin
            asm_q <= '0;
        end else begin
            case (ctr)
                2'd0:    asm_q[3:0]  <= i_is_mem_data;
                2'd1:    asm_q[7:4]  <= i_is_mem_data;
                2'd2:    asm_q[11:8] <= i_is_mem_data;
                default: asm_q       <= asm_q;
            endcase
        end
    end

    always_ff @(posedge i_is_gck or negedge i_is_rst_n) begin
        if (!i_is_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (push) begin
            q_mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge i_is_gck or negedge i_is_rst_n) begin
        if (!i_is_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= RESET_PC;
        end else if (boundary) begin
            if (i_is_redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                pc     <= i_is_redirect_pc;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    pc     <= pc + 16'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_idli_issue_m.sv
// Purpose : self-checking bench for idli_issue_m against a slot-level queue model.
// Latency : model issues a word only from the slot after its delivery.
// Backpress: model stops fetching while it holds DEPTH words.
module tb_idli_issue_m;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctr;
    logic        mem_req;
    logic [15:0] mem_pc;
    logic [3:0]  mem_data = '0;
    logic        mem_vld = 1'b0;
    logic [3:0]  enc;
    logic        enc_vld;
    logic        stall_i = 1'b0;
    logic        redir_i = 1'b0;
    logic [15:0] rpc_i = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction queue as a plain list of words plus fetch pc.
    logic [15:0] mq[$];
    logic [15:0] mpc;

    idli_issue_m #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_is_gck        (clk),
        .i_is_rst_n      (rst_n),
        .o_is_ctr        (ctr),
        .o_is_mem_req    (mem_req),
        .o_is_mem_pc     (mem_pc),
        .i_is_mem_data   (mem_data),
        .i_is_mem_vld    (mem_vld),
        .o_is_enc        (enc),
        .o_is_enc_vld    (enc_vld),
        .i_is_stall      (stall_i),
        .i_is_redirect   (redir_i),
        .i_is_redirect_pc(rpc_i)
    );

    always #5 clk = ~clk;

    // Run one whole slot: serial word w, control sampled at ctr==3, outputs compared each cycle.
    task automatic drive_slot(input logic [15:0] w, input logic vld, input logic stall,
                              input logic redir, input logic [15:0] rpc, input string tag);
        logic        exp_req;
        logic        exp_vld;
        logic [15:0] hd;
        logic        do_pop;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_data = w[c*4 +: 4];
            if (c == 3) begin
                mem_vld = vld; stall_i = stall; redir_i = redir; rpc_i = rpc;
            end else begin
                // Controls are only meaningful at ctr==3; anything else must be ignored.
                mem_vld = 1'($urandom); stall_i = 1'($urandom);
                redir_i = 1'($urandom); rpc_i = 16'($urandom);
            end
            #1;
            exp_req = (mq.size() < DEPTH);
            exp_vld = (mq.size() != 0) && !(c == 3 && redir);
            checks++;
            if (ctr !== 2'(c)) begin
                errors++; $display("FAIL %s ctr: got %0d want %0d", tag, ctr, c);
            end
            checks++;
            if (mem_req !== exp_req) begin
                errors++; $display("FAIL %s mem_req c%0d: got %b want %b", tag, c, mem_req, exp_req);
            end
            checks++;
            if (mem_pc !== mpc) begin
                errors++; $display("FAIL %s mem_pc c%0d: got %h want %h", tag, c, mem_pc, mpc);
            end
            checks++;
            if (enc_vld !== exp_vld) begin
                errors++; $display("FAIL %s enc_vld c%0d: got %b want %b", tag, c, enc_vld, exp_vld);
            end
            if (exp_vld) begin
                hd = mq[0];
                checks++;
                if (enc !== hd[c*4 +: 4]) begin
                    errors++; $display("FAIL %s enc c%0d: got %h want %h", tag, c, enc, hd[c*4 +: 4]);
                end
            end
        end
        // Slot-boundary update of the model.
        if (redir) begin
            mq.delete();
            mpc = rpc;
        end else begin
            do_pop = (mq.size() != 0) && !stall;
            if (do_pop) void'(mq.pop_front());
            if (exp_req && vld) begin
                mq.push_back(w);
                mpc = mpc + 16'd1;
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        mq.delete();
        mpc = RESET_PC;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ctr !== 2'd0) begin errors++; $display("FAIL reset ctr: got %0d want 0", ctr); end
        checks++;
        if (mem_pc !== RESET_PC) begin errors++; $display("FAIL reset mem_pc: got %h want %h", mem_pc, RESET_PC); end
        checks++;
        if (enc_vld !== 1'b0) begin errors++; $display("FAIL reset enc_vld: got %b want 0", enc_vld); end
        checks++;
        if (enc !== 4'h0) begin errors++; $display("FAIL reset enc: got %h want 0", enc); end
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL reset mem_req: got %b want 1", mem_req); end
        release_reset();
    endtask

    task automatic test_fetch_issue();
        drive_slot(16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, "fetch0");
        drive_slot(16'hABCD, 1'b1, 1'b0, 1'b0, 16'h0, "fetch1");
        drive_slot(16'h5555, 1'b1, 1'b0, 1'b0, 16'h0, "fetch2");
    endtask

    task automatic test_stall_fill();
        drive_slot(16'h2468, 1'b1, 1'b1, 1'b0, 16'h0, "stall0");
        drive_slot(16'h1357, 1'b1, 1'b1, 1'b0, 16'h0, "stall1");
        // Queue now full: request must be down for the whole next slot.
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_full mem_req: got %b want 0", mem_req); end
        drive_slot(16'h9999, 1'b1, 1'b1, 1'b0, 16'h0, "stall2");
        drive_slot(16'h7777, 1'b1, 1'b0, 1'b0, 16'h0, "unstall0");
        drive_slot(16'h6666, 1'b1, 1'b0, 1'b0, 16'h0, "unstall1");
        drive_slot(16'h4444, 1'b1, 1'b0, 1'b0, 16'h0, "unstall2");
    endtask

    task automatic test_mem_decline();
        drive_slot(16'h0BAD, 1'b1, 1'b0, 1'b1, 16'h0005, "decl_redir");
        drive_slot(16'hEEEE, 1'b0, 1'b0, 1'b0, 16'h0, "decl0");
        drive_slot(16'hDDDD, 1'b0, 1'b0, 1'b0, 16'h0, "decl1");
        @(posedge clk); #1;
        checks++;
        if (mem_pc !== 16'h0005) begin errors++; $display("FAIL decline mem_pc: got %h want 0005", mem_pc); end
        drive_slot(16'hC0DE, 1'b1, 1'b0, 1'b0, 16'h0, "decl_resume0");
        drive_slot(16'hF00D, 1'b1, 1'b0, 1'b0, 16'h0, "decl_resume1");
        drive_slot(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "decl_drain");
    endtask

    task automatic test_redirect();
        drive_slot(16'h1111, 1'b1, 1'b1, 1'b0, 16'h0, "redir_fill0");
        drive_slot(16'h2222, 1'b1, 1'b1, 1'b0, 16'h0, "redir_fill1");
        // Redirect with stall and an arriving word: redirect wins, word dropped.
        drive_slot(16'hDEAD, 1'b1, 1'b1, 1'b1, 16'h0100, "redir");
        @(posedge clk); #1;
        checks++;
        if (mem_pc !== 16'h0100) begin errors++; $display("FAIL redirect mem_pc: got %h want 0100", mem_pc); end
        checks++;
        if (enc_vld !== 1'b0) begin errors++; $display("FAIL redirect flush enc_vld: got %b want 0", enc_vld); end
        drive_slot(16'h3333, 1'b1, 1'b0, 1'b0, 16'h0, "redir_after0");
        drive_slot(16'h4444, 1'b1, 1'b0, 1'b0, 16'h0, "redir_after1");
    endtask

    task automatic test_pc_wrap();
        drive_slot(16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, "wrap_redir");
        drive_slot(16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0, "wrap_accept");
        @(posedge clk); #1;
        checks++;
        if (mem_pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap mem_pc: got %h want 0000", mem_pc); end
        drive_slot(16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h0, "wrap_next");
    endtask

    task automatic test_async_reset();
        drive_slot(16'h8888, 1'b1, 1'b1, 1'b0, 16'h0, "ar_fill0");
        drive_slot(16'h9999, 1'b1, 1'b1, 1'b0, 16'h0, "ar_fill1");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_data = 4'hF; mem_vld = 1'b1; stall_i = 1'b1; redir_i = 1'b0;
        end
        #1;
        checks++;
        if (ctr !== 2'd2) begin errors++; $display("FAIL ar_pre ctr: got %0d want 2", ctr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctr !== 2'd0) begin errors++; $display("FAIL ar ctr: got %0d want 0", ctr); end
        checks++;
        if (enc_vld !== 1'b0) begin errors++; $display("FAIL ar enc_vld: got %b want 0", enc_vld); end
        checks++;
        if (enc !== 4'h0) begin errors++; $display("FAIL ar enc: got %h want 0", enc); end
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL ar mem_req: got %b want 1", mem_req); end
        checks++;
        if (mem_pc !== RESET_PC) begin errors++; $display("FAIL ar mem_pc: got %h want %h", mem_pc, RESET_PC); end
        release_reset();
        drive_slot(16'h4321, 1'b1, 1'b0, 1'b0, 16'h0, "ar_after0");
        drive_slot(16'h8765, 1'b1, 1'b0, 1'b0, 16'h0, "ar_after1");
        drive_slot(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, "ar_after2");
    endtask

    task automatic test_random();
        logic        vld;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        for (int s = 0; s < 300; s++) begin
            vld   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            drive_slot(16'($urandom), vld, stall, redir, rpc, "random");
        end
    endtask

    initial begin
        test_reset();
        test_fetch_issue();
        test_stall_fill();
        test_mem_decline();
        test_redirect();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
